// File: rtl/ram_pkg.sv
// ----------------------------------------------------------------------------
// ram_pkg
// Shared definitions for the latched-address RAM and its bus-side initiator.
//   RAM_AW / RAM_DW : RAM address and data widths (64 KiB x 8).
//   BURST_LEN_W     : default width of a burst-length field.
//   state_t         : ram_master FSM states.
//   len_t           : burst length, in beats minus one.
// ----------------------------------------------------------------------------
package ram_pkg;

    localparam int RAM_AW      = 16;
    localparam int RAM_DW      = 8;
    localparam int BURST_LEN_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        XFER = 2'd2
    } state_t;

    typedef logic [BURST_LEN_W-1:0] len_t;

endpackage : ram_pkg

// File: rtl/ram_master.sv
// ----------------------------------------------------------------------------
// ram_master
// Bus-side initiator for the 64 KiB latched-address RAM. A host burst command
// becomes one address-latch cycle followed by one byte per clock: the RAM
// address for beat k+1 is latched in the same cycle that beat k is read or
// written.
//
// Optional build macro: RAM_MASTER_WRAP_ERR_EN
//   defined   : a burst that would run past 16'hFFFF is refused with a
//               done+err pulse the cycle after acceptance, no RAM activity.
//   undefined : addresses wrap modulo 2^16, err is tied to 0.
//
// Ports
//   clk, rst          : clock, asynchronous active-low reset
//   cmd_valid/ready   : command handshake (ready only while IDLE)
//   cmd_we/addr/len   : write/read, start address, beats minus one
//   wr_valid/data     : write byte stream; wr_ready marks consumption
//   rd_valid/data     : registered read byte stream, no backpressure
//   done, err         : end-of-burst pulse, refused-command pulse
//   busy              : FSM not IDLE
//   ram_*             : RAM address/latch/write-enable/data interface
// ----------------------------------------------------------------------------
module ram_master
    import ram_pkg::*;
#(
    parameter int LEN_W = BURST_LEN_W
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [RAM_AW-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,

    input  logic              wr_valid,
    input  logic [RAM_DW-1:0] wr_data,
    output logic              wr_ready,

    output logic              rd_valid,
    output logic [RAM_DW-1:0] rd_data,

    output logic              done,
    output logic              err,
    output logic              busy,

    output logic [RAM_AW-1:0] ram_addrs,
    output logic              ram_addrs_we,
    output logic              ram_mem_we,
    output logic [RAM_DW-1:0] ram_data_in,
    input  logic [RAM_DW-1:0] ram_data_out
);

    state_t              state_q;
    logic [RAM_AW-1:0]   cur_addr_q;
    logic [LEN_W-1:0]    count_q;
    logic                we_q;
    logic                rd_valid_q;
    logic [RAM_DW-1:0]   rd_data_q;
    logic                done_q;

    logic                accept;
    logic                beat;
    logic                last;
    logic [RAM_AW-1:0]   next_addr;

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign accept    = cmd_valid & cmd_ready;

    // A read beat happens every XFER cycle; a write beat only when a byte is offered.
    assign beat      = (state_q == XFER) && (!we_q || wr_valid);
    assign last      = (count_q == '0);
    assign next_addr = cur_addr_q + 16'd1;

    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign done      = done_q;

`ifdef RAM_MASTER_WRAP_ERR_EN
    logic              err_q;
    logic [RAM_AW:0]   end_addr;
    logic              overflow;

    // 17-bit sum: bit 16 set means the last beat would land past 16'hFFFF.
    assign end_addr = {1'b0, cmd_addr} + {{(RAM_AW + 1 - LEN_W){1'b0}}, cmd_len};
    assign overflow = end_addr[RAM_AW];
    assign err      = err_q;
`else
    assign err      = 1'b0;
`endif

    // RAM strobes are decoded from registered state plus wr_valid so that a
    // write beat and the next address latch land in the same cycle.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        ram_addrs    = '0;
        ram_addrs_we = 1'b0;
        ram_mem_we   = 1'b0;
        ram_data_in  = '0;
        wr_ready     = 1'b0;
        unique case (state_q)
            ADDR: begin
                ram_addrs    = cur_addr_q;
                ram_addrs_we = 1'b1;
            end
            XFER: begin
                wr_ready = we_q;
                if (beat) begin
                    if (we_q) begin
                        ram_mem_we  = 1'b1;
                        ram_data_in = wr_data;
                    end
                    // RAM writes at the old latched address while latching the next one.
                    if (!last) begin
                        ram_addrs    = next_addr;
                        ram_addrs_we = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cur_addr_q <= '0;
            count_q    <= '0;
            we_q       <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            done_q     <= 1'b0;
`ifdef RAM_MASTER_WRAP_ERR_EN
            err_q      <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking throughout so every register samples pre-edge values.
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
`ifdef RAM_MASTER_WRAP_ERR_EN
            err_q      <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        cur_addr_q <= cmd_addr;
                        count_q    <= cmd_len;
                        we_q       <= cmd_we;
                        state_q    <= ADDR;
`ifdef RAM_MASTER_WRAP_ERR_EN
                        // Refused burst: stay idle and report on the next cycle.
                        if (overflow) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end
`endif
                    end
                end
                ADDR: begin
                    state_q <= XFER;
                end
                XFER: begin
                    if (beat) begin
                        if (!we_q) begin
                            rd_data_q  <= ram_data_out;
                            rd_valid_q <= 1'b1;
                        end
                        if (last) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end else begin
                            cur_addr_q <= next_addr;
                            count_q    <= count_q - LEN_W'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule : ram_master

// File: tb/tb_ram_master.sv
// ----------------------------------------------------------------------------
// tb_ram_master
// Directed bench for ram_master with a behavioural latched-address RAM.
// Cycle n means the clock period after edge n; the command is accepted at
// edge 0. Outputs are sampled 1-2 time units after the rising edge.
// Build with +define+RAM_MASTER_WRAP_ERR_EN to exercise the refusal path.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ram_master;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [3:0]  cmd_len = '0;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        wr_ready;
    logic        rd_valid;
    logic [7:0]  rd_data;
    logic        done;
    logic        err;
    logic        busy;
    logic [15:0] ram_addrs;
    logic        ram_addrs_we;
    logic        ram_mem_we;
    logic [7:0]  ram_data_in;
    logic [7:0]  ram_data_out;

    int tests = 0;
    int fails = 0;

    ram_master #(.LEN_W(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .done(done), .err(err), .busy(busy),
        .ram_addrs(ram_addrs), .ram_addrs_we(ram_addrs_we),
        .ram_mem_we(ram_mem_we), .ram_data_in(ram_data_in),
        .ram_data_out(ram_data_out)
    );

    always #5 clk = ~clk;

    // Behavioural RAM: write at the old latched address, latch the new one.
    logic [7:0]  mem [0:65535];
    logic [15:0] lat = '0;
    assign ram_data_out = mem[lat];
    always @(posedge clk) begin
        if (ram_mem_we)   mem[lat] <= ram_data_in;
        if (ram_addrs_we) lat      <= ram_addrs;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic we, input logic [15:0] addr, input logic [3:0] len);
        cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
    endtask

    task automatic test_reset();
        step(); step();
        tests++; if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready got %b want 1", cmd_ready); end
        tests++; if ({busy, done, err, rd_valid, wr_ready, ram_addrs_we, ram_mem_we} !== 7'b0) begin
            fails++; $display("FAIL reset_flags got %b want 0000000", {busy, done, err, rd_valid, wr_ready, ram_addrs_we, ram_mem_we});
        end
        tests++; if ({rd_data, ram_addrs, ram_data_in} !== 32'h0) begin
            fails++; $display("FAIL reset_buses got %h want 0", {rd_data, ram_addrs, ram_data_in});
        end
        rst = 1'b1;
        step();
    endtask

    task automatic test_single_read();
        mem[16'h1234] = 8'hA5;
        start_cmd(1'b0, 16'h1234, 4'd0);
        step();                                       // cycle 1: ADDR
        cmd_valid = 1'b0;
        tests++; if (ram_addrs_we !== 1'b1 || ram_addrs !== 16'h1234) begin
            fails++; $display("FAIL rd1_addr_cycle got we=%b addr=%h want we=1 addr=1234", ram_addrs_we, ram_addrs);
        end
        tests++; if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
            fails++; $display("FAIL rd1_busy got busy=%b ready=%b want 1/0", busy, cmd_ready);
        end
        step();                                       // cycle 2: only beat
        tests++; if (ram_addrs_we !== 1'b0 || ram_addrs !== 16'h0 || rd_valid !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL rd1_beat got we=%b addr=%h rv=%b done=%b want 0/0000/0/0", ram_addrs_we, ram_addrs, rd_valid, done);
        end
        step();                                       // cycle 3
        tests++; if (rd_valid !== 1'b1 || rd_data !== 8'hA5) begin
            fails++; $display("FAIL rd1_data got rv=%b data=%h want 1/a5", rd_valid, rd_data);
        end
        tests++; if (done !== 1'b1 || err !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++; $display("FAIL rd1_done got done=%b err=%b ready=%b want 1/0/1", done, err, cmd_ready);
        end
        step();
    endtask

    task automatic test_write_burst();
        logic [7:0] d [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) mem[16'h0100 + i] = 8'h00;
        start_cmd(1'b1, 16'h0100, 4'd3);
        step();                                       // cycle 1
        cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = d[0];
        tests++; if (wr_ready !== 1'b0 || ram_mem_we !== 1'b0) begin
            fails++; $display("FAIL wr_addr_cycle got wr_ready=%b mem_we=%b want 0/0", wr_ready, ram_mem_we);
        end
        for (int i = 0; i < 4; i++) begin             // cycles 2..5
            step();
            wr_data = d[i];
            #1;
            tests++; if (ram_mem_we !== 1'b1 || ram_data_in !== d[i] || wr_ready !== 1'b1) begin
                fails++; $display("FAIL wr_beat%0d got we=%b data=%h rdy=%b want 1/%h/1", i, ram_mem_we, ram_data_in, wr_ready, d[i]);
            end
        end
        step();                                       // cycle 6
        wr_valid = 1'b0;
        tests++; if (done !== 1'b1 || ram_mem_we !== 1'b0) begin
            fails++; $display("FAIL wr_done got done=%b mem_we=%b want 1/0", done, ram_mem_we);
        end
        for (int i = 0; i < 4; i++) begin
            tests++; if (mem[16'h0100 + i] !== d[i]) begin
                fails++; $display("FAIL wr_mem%0d got %h want %h", i, mem[16'h0100 + i], d[i]);
            end
        end
        step();
    endtask

    task automatic test_write_stall();
        logic [7:0] d  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
        logic       wv [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int k = 0;
        for (int i = 0; i < 4; i++) mem[16'h0200 + i] = 8'h00;
        start_cmd(1'b1, 16'h0200, 4'd3);
        step();                                       // cycle 1
        cmd_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin             // cycles 2..7
            step();
            wr_valid = wv[c];
            wr_data  = wv[c] ? d[k] : 8'h00;
            #1;
            tests++; if (ram_mem_we !== wv[c] || wr_ready !== 1'b1 || done !== 1'b0) begin
                fails++; $display("FAIL stall_c%0d got we=%b rdy=%b done=%b want %b/1/0", c + 2, ram_mem_we, wr_ready, done, wv[c]);
            end
            if (!wv[c]) begin
                tests++; if (ram_addrs_we !== 1'b0 || ram_addrs !== 16'h0 || ram_data_in !== 8'h0) begin
                    fails++; $display("FAIL stall_quiet%0d got awe=%b addr=%h din=%h want 0/0000/00", c + 2, ram_addrs_we, ram_addrs, ram_data_in);
                end
            end
            if (wv[c]) k++;
        end
        step();                                       // cycle 8
        wr_valid = 1'b0;
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL stall_done got %b want 1", done); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (mem[16'h0200 + i] !== d[i]) begin
                fails++; $display("FAIL stall_mem%0d got %h want %h", i, mem[16'h0200 + i], d[i]);
            end
        end
        step();
    endtask

    task automatic test_back_to_back();
        start_cmd(1'b0, 16'h1234, 4'd0);
        step();                                       // cycle 1, first command taken
        start_cmd(1'b0, 16'h0100, 4'd1);              // second command held valid
        step(); step();                               // cycle 3: done of first
        tests++; if (done !== 1'b1 || cmd_ready !== 1'b1 || rd_data !== 8'hA5) begin
            fails++; $display("FAIL b2b_first got done=%b rdy=%b data=%h want 1/1/a5", done, cmd_ready, rd_data);
        end
        step();                                       // cycle 4: ADDR of second
        cmd_valid = 1'b0;
        tests++; if (ram_addrs_we !== 1'b1 || ram_addrs !== 16'h0100) begin
            fails++; $display("FAIL b2b_addr got we=%b addr=%h want 1/0100", ram_addrs_we, ram_addrs);
        end
        step(); step();                               // cycle 6
        tests++; if (rd_valid !== 1'b1 || rd_data !== 8'h11 || done !== 1'b0) begin
            fails++; $display("FAIL b2b_beat0 got rv=%b data=%h done=%b want 1/11/0", rd_valid, rd_data, done);
        end
        step();                                       // cycle 7
        tests++; if (rd_valid !== 1'b1 || rd_data !== 8'h22 || done !== 1'b1) begin
            fails++; $display("FAIL b2b_beat1 got rv=%b data=%h done=%b want 1/22/1", rd_valid, rd_data, done);
        end
        step();
    endtask

    task automatic test_wrap();
        logic [7:0] e [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        mem[16'hFFFE] = 8'h01; mem[16'hFFFF] = 8'h02;
        mem[16'h0000] = 8'h03; mem[16'h0001] = 8'h04;
        start_cmd(1'b0, 16'hFFFE, 4'd3);
        step();                                       // cycle 1
        cmd_valid = 1'b0;
`ifdef RAM_MASTER_WRAP_ERR_EN
        tests++; if (done !== 1'b1 || err !== 1'b1) begin
            fails++; $display("FAIL wrap_err got done=%b err=%b want 1/1", done, err);
        end
        tests++; if (ram_addrs_we !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            fails++; $display("FAIL wrap_quiet got awe=%b busy=%b rdy=%b want 0/0/1", ram_addrs_we, busy, cmd_ready);
        end
        step();
        tests++; if (done !== 1'b0 || err !== 1'b0 || ram_addrs_we !== 1'b0) begin
            fails++; $display("FAIL wrap_after got done=%b err=%b awe=%b want 0/0/0", done, err, ram_addrs_we);
        end
`else
        tests++; if (ram_addrs !== 16'hFFFE) begin fails++; $display("FAIL wrap_start got %h want fffe", ram_addrs); end
        step();                                       // cycle 2
        for (int i = 0; i < 4; i++) begin             // cycles 3..6
            step();
            if (i == 0) begin
                tests++; if (ram_addrs_we !== 1'b1 || ram_addrs !== 16'h0000) begin
                    fails++; $display("FAIL wrap_roll got we=%b addr=%h want 1/0000", ram_addrs_we, ram_addrs);
                end
            end
            tests++; if (rd_valid !== 1'b1 || rd_data !== e[i] || done !== (i == 3) || err !== 1'b0) begin
                fails++; $display("FAIL wrap_beat%0d got rv=%b data=%h done=%b err=%b want 1/%h/%b/0", i, rd_valid, rd_data, done, err, e[i], i == 3);
            end
        end
`endif
        step();
    endtask

    task automatic test_reset_mid_burst();
        int bad_we = 0;
        int bad_done = 0;
        for (int i = 0; i < 8; i++) mem[16'h0300 + i] = 8'h00;
        start_cmd(1'b1, 16'h0300, 4'd7);
        step();                                       // cycle 1
        cmd_valid = 1'b0; wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin             // beats in cycles 2..4
            step();
            wr_data = 8'h80 + 8'(i);
        end
        step();                                       // cycle 5, mid-burst
        wr_data = 8'h83;
        rst = 1'b0;
        #1;
        tests++; if (ram_mem_we !== 1'b0 || ram_addrs_we !== 1'b0 || wr_ready !== 1'b0) begin
            fails++; $display("FAIL mid_rst_strobes got we=%b awe=%b rdy=%b want 0/0/0", ram_mem_we, ram_addrs_we, wr_ready);
        end
        tests++; if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            fails++; $display("FAIL mid_rst_state got rdy=%b busy=%b done=%b want 1/0/0", cmd_ready, busy, done);
        end
        step();
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            if (ram_mem_we !== 1'b0) bad_we++;
            if (done !== 1'b0) bad_done++;
        end
        wr_valid = 1'b0;
        tests++; if (bad_we != 0 || bad_done != 0) begin
            fails++; $display("FAIL mid_rst_after got mem_we_cycles=%0d done_cycles=%0d want 0/0", bad_we, bad_done);
        end
        tests++; if ({mem[16'h0300], mem[16'h0301], mem[16'h0302], mem[16'h0303]} !== 32'h80818200) begin
            fails++; $display("FAIL mid_rst_mem got %h%h%h%h want 80818200", mem[16'h0300], mem[16'h0301], mem[16'h0302], mem[16'h0303]);
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write_burst();
        test_write_stall();
        test_back_to_back();
        test_wrap();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_ram_master
